// File: rtl/iob_uart_core.sv
// iob_uart_core: 8N1 UART transceiver with RTS/CTS flow control and a
// runtime-programmable bit period. Serial pins are registered; the register
// wrapper above drives enables, the divisor and single-cycle strobes.
module iob_uart_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rst_soft,
  input  logic              tx_en,
  input  logic              rx_en,
  output logic              tx_ready,
  output logic              rx_ready,
  input  logic [7:0]        tx_data,
  output logic [7:0]        rx_data,
  input  logic              data_write_en,
  input  logic              data_read_en,
  input  logic [DATA_W-1:0] bit_duration,
  input  logic              rxd,
  output logic              txd,
  input  logic              cts,
  output logic              rts
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Last counter value of a full bit and of the half bit before the mid-bit sample
  logic [DATA_W-1:0] bit_last;
  logic [DATA_W-1:0] half_last;
  assign bit_last  = bit_duration - DATA_W'(1);
  assign half_last = (bit_duration >> 1) - DATA_W'(1);

  // Transmitter state
  logic [1:0]        tx_state_q, tx_state_d;
  logic [DATA_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              txd_q, txd_d;
  // Held low for one cycle after any reset so tx_ready reads 0 right after it
  logic              tx_arm_q, tx_arm_d;

  // Receiver state
  logic              rxd_s1_q, rxd_s1_d;
  logic              rxd_s2_q, rxd_s2_d;
  logic [1:0]        rx_state_q, rx_state_d;
  logic [DATA_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic              rx_done_q, rx_done_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic              rx_ready_q, rx_ready_d;
  logic              rts_q, rts_d;

  assign tx_ready = tx_en & cts & tx_arm_q & (tx_state_q == ST_IDLE);
  assign txd      = txd_q;
  assign rx_ready = rx_ready_q;
  assign rx_data  = rx_data_q;
  assign rts      = rts_q;

  // TX frame sequencer: start bit, 8 data bits LSB first, stop bit
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + DATA_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    tx_arm_d   = 1'b1;
    case (tx_state_q)
      ST_IDLE: begin
        tx_cnt_d = '0;
        if (data_write_en && tx_ready) begin
          tx_state_d = ST_START;
          tx_shift_d = tx_data;
          txd_d      = 1'b0;
        end
      end
      ST_START: begin
        if (tx_cnt_q >= bit_last) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_DATA;
          tx_bit_d   = 3'd0;
          txd_d      = tx_shift_q[0];
        end
      end
      ST_DATA: begin
        if (tx_cnt_q >= bit_last) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            txd_d      = tx_shift_q[1];
          end
        end
      end
      default: begin
        if (tx_cnt_q >= bit_last) begin
          tx_cnt_d   = '0;
          tx_state_d = ST_IDLE;
        end
      end
    endcase
    if (rst_soft) begin
      tx_state_d = ST_IDLE;
      tx_cnt_d   = '0;
      tx_bit_d   = 3'd0;
      tx_shift_d = 8'h00;
      txd_d      = 1'b1;
      tx_arm_d   = 1'b0;
    end
  end

  // RX: synchronizer, mid-bit sampling FSM and the rx_data/rx_ready holding register
  always_comb begin
    rxd_s1_d   = rxd;
    rxd_s2_d   = rxd_s1_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DATA_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_done_d  = 1'b0;
    rx_data_d  = rx_data_q;
    rx_ready_d = rx_ready_q;
    rts_d      = rx_en;
    // A completing byte takes priority over a read in the same cycle
    if (rx_done_q) begin
      rx_data_d  = rx_shift_q;
      rx_ready_d = 1'b1;
    end else if (data_read_en) begin
      rx_ready_d = 1'b0;
    end
    if (!rx_en) begin
      rx_state_d = ST_IDLE;
      rx_cnt_d   = '0;
      rx_bit_d   = 3'd0;
    end else begin
      case (rx_state_q)
        ST_IDLE: begin
          rx_cnt_d = '0;
          // Falling edge on the synchronized line, seen one flop early
          if (!rxd_s1_q && rxd_s2_q) rx_state_d = ST_START;
        end
        ST_START: begin
          if (rx_cnt_q >= half_last) begin
            rx_cnt_d   = '0;
            rx_bit_d   = 3'd0;
            rx_state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (rx_cnt_q >= bit_last) begin
            rx_cnt_d   = '0;
            rx_shift_d = {rxd_s2_q, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
            else rx_bit_d = rx_bit_q + 3'd1;
          end
        end
        default: begin
          if (rx_cnt_q >= bit_last) begin
            rx_cnt_d   = '0;
            rx_state_d = ST_IDLE;
            rx_done_d  = rxd_s2_q;
          end
        end
      endcase
    end
    if (rst_soft) begin
      rxd_s1_d   = 1'b1;
      rxd_s2_d   = 1'b1;
      rx_state_d = ST_IDLE;
      rx_cnt_d   = '0;
      rx_bit_d   = 3'd0;
      rx_shift_d = 8'h00;
      rx_done_d  = 1'b0;
      rx_data_d  = 8'h00;
      rx_ready_d = 1'b0;
      rts_d      = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= ST_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= 3'd0;
      tx_shift_q <= 8'h00;
      txd_q      <= 1'b1;
      tx_arm_q   <= 1'b0;
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rx_state_q <= ST_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= 3'd0;
      rx_shift_q <= 8'h00;
      rx_done_q  <= 1'b0;
      rx_data_q  <= 8'h00;
      rx_ready_q <= 1'b0;
      rts_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
      tx_arm_q   <= tx_arm_d;
      rxd_s1_q   <= rxd_s1_d;
      rxd_s2_q   <= rxd_s2_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_done_q  <= rx_done_d;
      rx_data_q  <= rx_data_d;
      rx_ready_q <= rx_ready_d;
      rts_q      <= rts_d;
    end
  end

endmodule

// File: tb/tb_iob_uart_core.sv
// tb_iob_uart_core: flow-control and RX tables, hand-written corner cases,
// randomized RX frames against a ready/data model, and loopback TX frames
// checked against the ideal serial waveform.
module tb_iob_uart_core;

  logic        clk = 1'b0;
  logic        rst, rst_soft, tx_en, rx_en;
  logic        data_write_en, data_read_en;
  logic [7:0]  tx_data;
  logic [31:0] bit_duration;
  logic        tx_ready, rx_ready, txd, rts;
  logic [7:0]  rx_data;
  logic        rxd, cts;
  logic        loop_mode, rxd_drv, cts_drv;

  int checks = 0;
  int errors = 0;

  // Model of the receive holding register
  logic       ready_m;
  logic [7:0] data_m;

  always #5 clk = ~clk;

  assign rxd = loop_mode ? txd : rxd_drv;
  assign cts = loop_mode ? rts : cts_drv;

  iob_uart_core #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst), .rst_soft(rst_soft), .tx_en(tx_en), .rx_en(rx_en),
    .tx_ready(tx_ready), .rx_ready(rx_ready), .tx_data(tx_data), .rx_data(rx_data),
    .data_write_en(data_write_en), .data_read_en(data_read_en),
    .bit_duration(bit_duration), .rxd(rxd), .txd(txd), .cts(cts), .rts(rts)
  );

  typedef struct {
    logic tx_en;
    logic cts;
    logic rx_en;
    logic exp_tx_ready;
    logic exp_rts;
  } fc_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       read_after;
    logic       exp_ready;
    logic [7:0] exp_data;
  } rx_vec_t;

  fc_vec_t fc_tab[6];
  rx_vec_t rx_tab[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_read();
    data_read_en = 1'b1;
    tick();
    data_read_en = 1'b0;
  endtask

  // Drive one frame on the rxd pin (start, 8 data LSB first, given stop bit), then idle
  task automatic drive_frame(input logic [7:0] b, input logic stop, input int d);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    bit_duration = d;
    for (int c = 0; c < 10 * d; c++) begin
      rxd_drv = fr[c / d];
      tick();
    end
    rxd_drv = 1'b1;
    repeat (6) tick();
  endtask

  // Loopback send: check the txd waveform, tx_ready timing, RX latency and data
  task automatic send_byte(input logic [7:0] b, input int d, input bit intrude);
    logic [9:0] fr;
    int n, bad, lows, rx_rise;
    bit_duration = d;
    n = 0;
    while (tx_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check("tx_ready_before_write", tx_ready, 1);
    tx_data = b;
    data_write_en = 1'b1;
    tick();
    data_write_en = 1'b0;
    fr = {1'b1, b, 1'b0};
    bad = 0;
    lows = 0;
    rx_rise = -1;
    for (int m = 0; m <= 10 * d + 4; m++) begin
      if (m < 10 * d) begin
        if (txd !== fr[m / d] || tx_ready !== 1'b0) bad++;
        if (txd === 1'b0) lows++;
      end else if (txd !== 1'b1) begin
        bad++;
      end
      if (m == 10 * d) check("tx_ready_return", tx_ready, 1);
      if (rx_rise < 0 && rx_ready === 1'b1) rx_rise = m;
      if (intrude && m == 3 * d) begin
        tx_data = 8'h3C;
        data_write_en = 1'b1;
      end else begin
        data_write_en = 1'b0;
      end
      tick();
    end
    check("tx_waveform", bad, 0);
    check("tx_low_time", lows, (9 - $countones(b)) * d);
    check("rx_latency", rx_rise, 3 + d / 2 + 9 * d);
    check("rx_loop_data", rx_data, b);
    do_read();
    check("rx_read_clear", rx_ready, 0);
  endtask

  initial begin
    logic [9:0] fr;
    int bad, cr, d;
    logic [7:0] b;
    logic stop, rd;

    fc_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    fc_tab[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    fc_tab[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    fc_tab[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    fc_tab[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    fc_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    rx_tab[0] = '{8'h3C, 1'b0, 1'b0, 1'b0, 8'h00};
    rx_tab[1] = '{8'h5A, 1'b1, 1'b1, 1'b1, 8'h5A};
    rx_tab[2] = '{8'h11, 1'b1, 1'b0, 1'b1, 8'h11};
    rx_tab[3] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'h22};
    rx_tab[4] = '{8'h99, 1'b0, 1'b0, 1'b0, 8'h22};
    rx_tab[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 8'h00};
    rx_tab[6] = '{8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF};
    rx_tab[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 8'hFF};

    rst = 1'b0; rst_soft = 1'b0; tx_en = 1'b0; rx_en = 1'b0;
    data_write_en = 1'b0; data_read_en = 1'b0; tx_data = 8'h00;
    bit_duration = 32'd8; loop_mode = 1'b0; rxd_drv = 1'b1; cts_drv = 1'b0;

    // Hard reset values
    repeat (3) tick();
    check("reset_txd", txd, 1);
    check("reset_tx_ready", tx_ready, 0);
    check("reset_rx_ready", rx_ready, 0);
    check("reset_rts", rts, 0);
    check("reset_rx_data", rx_data, 0);
    rst = 1'b1;
    tx_en = 1'b1;
    repeat (4) tick();
    check("tx_ready_cts_low", tx_ready, 0);

    // Flow-control table
    for (int i = 0; i < 6; i++) begin
      tx_en = fc_tab[i].tx_en;
      cts_drv = fc_tab[i].cts;
      rx_en = fc_tab[i].rx_en;
      tick();
      check($sformatf("fc%0d_tx_ready", i), tx_ready, fc_tab[i].exp_tx_ready);
      check($sformatf("fc%0d_rts", i), rts, fc_tab[i].exp_rts);
      $display("fc vector %0d: tx_en=%0b cts=%0b rx_en=%0b -> tx_ready=%0b rts=%0b",
               i, tx_en, cts_drv, rx_en, tx_ready, rts);
    end

    // Receive table: framing errors, overrun, reads
    rx_en = 1'b1; tx_en = 1'b0; cts_drv = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive_frame(rx_tab[i].data, rx_tab[i].stop, 8);
      check($sformatf("rx%0d_ready", i), rx_ready, rx_tab[i].exp_ready);
      check($sformatf("rx%0d_data", i), rx_data, rx_tab[i].exp_data);
      $display("rx vector %0d: byte=0x%02h stop=%0b -> rx_ready=%0b rx_data=0x%02h",
               i, rx_tab[i].data, rx_tab[i].stop, rx_ready, rx_data);
      if (rx_tab[i].read_after) begin
        do_read();
        check($sformatf("rx%0d_read_clear", i), rx_ready, 0);
      end
    end

    // Completion and read strobe in the same cycle: completion wins
    drive_frame(8'h11, 1'b1, 8);
    check("race_pre_ready", rx_ready, 1);
    d = 8;
    fr = {1'b1, 8'h77, 1'b0};
    cr = 2 + d / 2 + 9 * d;
    for (int c = 0; c < 10 * d + 6; c++) begin
      if (c == cr) check("race_old_data", rx_data, 8'h11);
      if (c == cr + 1) begin
        check("race_ready", rx_ready, 1);
        check("race_new_data", rx_data, 8'h77);
      end
      if (c == cr + 2) check("race_ready_held", rx_ready, 1);
      rxd_drv = (c < 10 * d) ? fr[c / d] : 1'b1;
      data_read_en = (c == cr);
      tick();
    end
    data_read_en = 1'b0;
    $display("race: byte=0x77 -> rx_ready=%0b rx_data=0x%02h", rx_ready, rx_data);

    // Dropping rx_en mid-frame discards the byte
    do_read();
    check("abort_pre_clear", rx_ready, 0);
    fr = {1'b1, 8'hFF, 1'b0};
    bad = 0;
    for (int c = 0; c < 10 * d + 8; c++) begin
      if (c == 3 * d + 1) check("abort_rts_low", rts, 0);
      if (rx_ready !== 1'b0) bad++;
      rxd_drv = (c < 10 * d) ? fr[c / d] : 1'b1;
      rx_en = (c != 3 * d);
      tick();
    end
    rx_en = 1'b1;
    check("abort_no_byte", bad, 0);
    check("abort_data_kept", rx_data, 8'h77);
    check("abort_rts_back", rts, 1);
    $display("abort: rx_en dropped mid-frame -> rx_ready=%0b", rx_ready);

    // Randomized receive frames against the holding-register model
    ready_m = 1'b0;
    data_m = 8'h77;
    for (int i = 0; i < 30; i++) begin
      d = $urandom_range(4, 12);
      b = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      rd = 1'($urandom_range(0, 1));
      drive_frame(b, stop, d);
      if (stop) begin
        ready_m = 1'b1;
        data_m = b;
      end
      check("rnd_rx_ready", rx_ready, ready_m);
      check("rnd_rx_data", rx_data, data_m);
      $display("rnd rx %0d: D=%0d byte=0x%02h stop=%0b -> rx_ready=%0b rx_data=0x%02h",
               i, d, b, stop, rx_ready, rx_data);
      if (rd) begin
        do_read();
        ready_m = 1'b0;
        check("rnd_rx_read", rx_ready, ready_m);
      end
    end
    if (ready_m) do_read();

    // Loopback
    loop_mode = 1'b1;
    tx_en = 1'b1;
    rx_en = 1'b1;
    repeat (4) tick();
    send_byte(8'h00, 100, 1'b0);
    $display("loopback D=100 byte=0x00 -> rx_data=0x%02h", rx_data);

    // Write during a frame is ignored
    send_byte(8'hA5, 100, 1'b1);
    bad = 0;
    for (int c = 0; c < 12 * 100; c++) begin
      if (rx_ready !== 1'b0 || txd !== 1'b1) bad++;
      tick();
    end
    check("ignored_write_quiet", bad, 0);
    $display("ignored write: only 0xA5 sent, rx_data=0x%02h", rx_data);

    // Soft reset in the middle of a 0xFF frame
    bit_duration = 100;
    bad = 0;
    while (tx_ready !== 1'b1 && bad < 100) begin
      tick();
      bad++;
    end
    check("soft_tx_ready_before", tx_ready, 1);
    tx_data = 8'hFF;
    data_write_en = 1'b1;
    tick();
    data_write_en = 1'b0;
    repeat (300) tick();
    rst_soft = 1'b1;
    tick();
    rst_soft = 1'b0;
    check("soft_txd", txd, 1);
    check("soft_tx_ready_low", tx_ready, 0);
    check("soft_rts_low", rts, 0);
    tick();
    check("soft_tx_ready_back", tx_ready, 1);
    bad = 0;
    for (int c = 0; c < 12 * 100; c++) begin
      if (rx_ready !== 1'b0 || txd !== 1'b1) bad++;
      tick();
    end
    check("soft_no_byte", bad, 0);
    $display("soft reset mid-frame: txd=%0b rx_ready=%0b", txd, rx_ready);

    // Full byte sweep with small, varied bit periods
    for (int i = 0; i < 256; i++) begin
      send_byte(8'(i), 4 + (i % 6), 1'b0);
      $display("sweep byte=0x%02h D=%0d -> rx_data=0x%02h", i, 4 + (i % 6), rx_data);
    end

    // Random loopback frames
    for (int i = 0; i < 12; i++) begin
      d = $urandom_range(4, 16);
      b = 8'($urandom);
      send_byte(b, d, 1'b0);
      $display("rnd tx %0d: D=%0d byte=0x%02h -> rx_data=0x%02h", i, d, b, rx_data);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
